// File: rtl/trim_pwm_pkg.sv
// Shared definitions for the trim PWM generator and capture blocks:
// FSM state encoding and width helpers derived from the PWM resolution.
package trim_pwm_pkg;

  localparam int RES_MIN = 8;
  localparam int RES_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // One extra bit so a full 2^res period is representable.
  function automatic int cnt_width(input int res);
    return res + 1;
  endfunction

  function automatic int sat_value(input int res);
    return (2 ** (res + 1)) - 1;
  endfunction

endpackage

// File: rtl/trim_pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM input, followed by a
// previous-value flop that yields single-cycle rise and fall strobes.
module trim_pwm_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pwm_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/trim_pwm_capture.sv
// Measures high time and period of an incoming PWM waveform in clock cycles;
// one valid pulse per completed period, sticky overflow on counter saturation.
module trim_pwm_capture
  import trim_pwm_pkg::*;
#(
  parameter int Resolution = 8,
  localparam int W = cnt_width(Resolution)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] high_count,
  output logic [W-1:0] period_count,
  output logic         valid,
  output logic         overflow,
  output logic         level,
  output state_t       state
);

  localparam logic [W-1:0] SAT = W'(sat_value(Resolution));

  // Handshake: valid is a one-cycle strobe with no ready; high_count and
  // period_count change only in the cycle valid is high and hold otherwise.

  logic         rise;
  logic         fall;
  logic [W-1:0] counter;
  logic [W-1:0] high_q;
  logic         sat_seen;
  logic         at_sat;

  trim_pwm_edge_sync u_edge_sync (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign at_sat = (counter == SAT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      counter      <= '0;
      high_q       <= '0;
      sat_seen     <= 1'b0;
      high_count   <= '0;
      period_count <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        // Abort: results and the sticky flag are left untouched.
        state    <= ST_IDLE;
        counter  <= '0;
        sat_seen <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state    <= ST_HIGH;
              counter  <= W'(1);
              sat_seen <= 1'b0;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              state  <= ST_LOW;
              high_q <= counter;
            end
            if (at_sat) begin
              sat_seen <= 1'b1;
              overflow <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
          ST_LOW: begin
            if (rise) begin
              state    <= ST_HIGH;
              counter  <= W'(1);
              sat_seen <= 1'b0;
              // A saturated period is discarded; the new rise just restarts.
              if (!sat_seen) begin
                high_count   <= high_q;
                period_count <= counter;
                valid        <= 1'b1;
                overflow     <= 1'b0;
              end
            end else if (at_sat) begin
              sat_seen <= 1'b1;
              overflow <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trim_pwm_capture.sv
// Self-checking bench for trim_pwm_capture at Resolution 8 and 16, using a
// period-list reference model of the expected (high, period) reports.
module tb_trim_pwm_capture;
  import trim_pwm_pkg::*;

  localparam int W8  = 9;
  localparam int W16 = 17;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en    = 1'b0;
  logic pwm8  = 1'b0;
  logic pwm16 = 1'b0;

  logic [W8-1:0]  hc8, pc8;
  logic           v8, ov8, lv8;
  state_t         st8;
  logic [W16-1:0] hc16, pc16;
  logic           v16, ov16, lv16;
  state_t         st16;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  logic [2*W8-1:0]  exp_q[$];
  logic [2*W8-1:0]  obs_q[$];
  int unsigned      obs_cyc[$];
  logic [2*W16-1:0] obs16_q[$];

  trim_pwm_capture #(.Resolution(8)) dut8 (
    .clock(clock), .reset(reset), .en(en), .pwm_in(pwm8),
    .high_count(hc8), .period_count(pc8), .valid(v8),
    .overflow(ov8), .level(lv8), .state(st8)
  );

  trim_pwm_capture #(.Resolution(16)) dut16 (
    .clock(clock), .reset(reset), .en(en), .pwm_in(pwm16),
    .high_count(hc16), .period_count(pc16), .valid(v16),
    .overflow(ov16), .level(lv16), .state(st16)
  );

  // Clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: record every report away from the active edge
  always @(negedge clock) begin
    if (v8) begin
      obs_q.push_back({hc8, pc8});
      obs_cyc.push_back(cyc);
    end
    if (v16) obs16_q.push_back({hc16, pc16});
  end

  // Driver: one PWM period, called at a falling clock edge. When tracked,
  // the reference model expects this period reported once the next rise
  // arrives, unless it is too long for the counter.
  task automatic drive8(input int h, input int p, input bit track);
    pwm8 = 1'b1;
    repeat (h) @(negedge clock);
    pwm8 = 1'b0;
    repeat (p - h) @(negedge clock);
    if (track && p < (1 << W8)) exp_q.push_back({h[W8-1:0], p[W8-1:0]});
  endtask

  task automatic close_rise();
    pwm8 = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic restart();
    @(negedge clock);
    en = 1'b0;
    pwm8 = 1'b0;
    pwm16 = 1'b0;
    repeat (4) @(negedge clock);
    en = 1'b1;
    repeat (2) @(negedge clock);
    obs_q.delete();
    obs_cyc.delete();
    obs16_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({hc8, pc8, v8, ov8, lv8} !== '0) begin
      errors++;
      $display("FAIL reset_out8: got hc=%0d pc=%0d v=%b ov=%b lv=%b expected all 0", hc8, pc8, v8, ov8, lv8);
    end
    checks++;
    if ({hc16, pc16, v16, ov16, lv16} !== '0) begin
      errors++;
      $display("FAIL reset_out16: got hc=%0d pc=%0d expected 0", hc16, pc16);
    end
    checks++;
    if (st8 !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", st8, ST_IDLE);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_gen256();
    int unsigned rise2 = 0;
    restart();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) rise2 = cyc;
      drive8(64, 256, 1'b1);
    end
    close_rise();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gen256_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gen256_entry%0d: got %0d/%0d expected %0d/%0d", i,
                 obs_q[i][2*W8-1:W8], obs_q[i][W8-1:0], exp_q[i][2*W8-1:W8], exp_q[i][W8-1:0]);
      end
    end
    if (obs_cyc.size() > 0) begin
      checks++;
      if (obs_cyc[0] != rise2 + 3) begin
        errors++;
        $display("FAIL gen256_first_valid: got cycle %0d expected %0d", obs_cyc[0], rise2 + 3);
      end
    end
    checks++;
    if (ov8 !== 1'b0) begin
      errors++;
      $display("FAIL gen256_overflow: got %b expected 0", ov8);
    end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 8; i++) begin
      int p = $urandom_range(400, 2);
      int h = $urandom_range(p - 1, 1);
      drive8(h, p, 1'b1);
    end
    close_rise();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_entry%0d: got %0d/%0d expected %0d/%0d", i,
                 obs_q[i][2*W8-1:W8], obs_q[i][W8-1:0], exp_q[i][2*W8-1:W8], exp_q[i][W8-1:0]);
      end
    end
  endtask

  task automatic test_overflow();
    restart();
    checks++;
    if (ov8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre: got %b expected 0", ov8);
    end
    drive8(5, 605, 1'b1);
    checks++;
    if (ov8 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", ov8);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_no_valid: got %0d reports expected 0", obs_q.size());
    end
    checks++;
    if (lv8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_level: got %b expected 0", lv8);
    end
    drive8(30, 100, 1'b1);
    drive8(30, 100, 1'b1);
    close_rise();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_entry%0d: got %0d/%0d expected %0d/%0d", i,
                 obs_q[i][2*W8-1:W8], obs_q[i][W8-1:0], exp_q[i][2*W8-1:W8], exp_q[i][W8-1:0]);
      end
    end
    checks++;
    if (ov8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared: got %b expected 0", ov8);
    end
  endtask

  task automatic test_en_abort();
    restart();
    drive8(20, 50, 1'b1);
    pwm8 = 1'b1;
    repeat (5) @(negedge clock);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (v8 !== 1'b0 || hc8 !== 9'd20 || pc8 !== 9'd50) begin
        errors++;
        $display("FAIL en_hold%0d: got v=%b %0d/%0d expected v=0 20/50", i, v8, hc8, pc8);
      end
    end
    checks++;
    if (lv8 !== 1'b1) begin
      errors++;
      $display("FAIL en_level: got %b expected 1", lv8);
    end
    en = 1'b1;
    repeat (15) @(negedge clock);
    pwm8 = 1'b0;
    repeat (30) @(negedge clock);
    drive8(25, 60, 1'b1);
    drive8(25, 60, 1'b1);
    close_rise();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL en_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL en_entry%0d: got %0d/%0d expected %0d/%0d", i,
                 obs_q[i][2*W8-1:W8], obs_q[i][W8-1:0], exp_q[i][2*W8-1:W8], exp_q[i][W8-1:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    restart();
    drive8(10, 40, 1'b0);
    pwm8 = 1'b1;
    repeat (10) @(negedge clock);
    pwm8 = 1'b0;
    repeat (15) @(negedge clock);
    checks++;
    if (hc8 !== 9'd10 || pc8 !== 9'd40) begin
      errors++;
      $display("FAIL arst_pre: got %0d/%0d expected 10/40", hc8, pc8);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({hc8, pc8, v8, ov8, lv8} !== '0 || st8 !== ST_IDLE) begin
      errors++;
      $display("FAIL arst_now: got hc=%0d pc=%0d v=%b ov=%b st=%0d expected all 0", hc8, pc8, v8, ov8, st8);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    @(negedge clock);
    drive8(10, 40, 1'b1);
    drive8(10, 40, 1'b0);
    repeat (5) @(negedge clock);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL arst_count: got %0d expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL arst_entry: got %0d/%0d expected 10/40", obs_q[0][2*W8-1:W8], obs_q[0][W8-1:0]);
      end
    end
  endtask

  task automatic test_min();
    int unsigned rise2 = 0;
    restart();
    for (int i = 0; i < 8; i++) begin
      if (i == 1) rise2 = cyc;
      drive8(1, 2, 1'b1);
    end
    close_rise();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL min_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL min_entry%0d: got %0d/%0d expected 1/2", i, obs_q[i][2*W8-1:W8], obs_q[i][W8-1:0]);
      end
      if (i > 0) begin
        checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL min_spacing%0d: got %0d expected 2", i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
    if (obs_cyc.size() > 0) begin
      checks++;
      if (obs_cyc[0] != rise2 + 3) begin
        errors++;
        $display("FAIL min_latency: got cycle %0d expected %0d", obs_cyc[0], rise2 + 3);
      end
    end
  endtask

  task automatic test_res16();
    logic [2*W16-1:0] exp16;
    restart();
    exp16 = {17'd65535, 17'd65536};
    pwm16 = 1'b1;
    repeat (65535) @(negedge clock);
    pwm16 = 1'b0;
    @(negedge clock);
    pwm16 = 1'b1;
    repeat (6) @(negedge clock);
    checks++;
    if (obs16_q.size() != 1) begin
      errors++;
      $display("FAIL res16_count: got %0d expected 1", obs16_q.size());
    end else begin
      checks++;
      if (obs16_q[0] !== exp16) begin
        errors++;
        $display("FAIL res16_entry: got %0d/%0d expected 65535/65536",
                 obs16_q[0][2*W16-1:W16], obs16_q[0][W16-1:0]);
      end
    end
    checks++;
    if (ov16 !== 1'b0) begin
      errors++;
      $display("FAIL res16_overflow: got %b expected 0", ov16);
    end
  endtask

  initial begin
    test_reset();
    test_gen256();
    test_random();
    test_overflow();
    test_en_abort();
    test_async_reset();
    test_min();
    test_res16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
